// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small circular FIFO feeds a START/DATA/STOP
// serialiser whose bit period is latched per frame from i_baud_div.
`timescale 1ns/1ps
module uart_tx_fifo #(
   parameter int DEPTH = 8,
   parameter int DIV_W = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_wr_en,
   input  logic [7:0]               i_wr_data,
   input  logic [DIV_W-1:0]         i_baud_div,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_overflow,
   output logic                     o_busy,
   output logic                     o_uart_tx
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state;
   logic [7:0]       mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic [DIV_W-1:0] div;
   logic [DIV_W-1:0] baud_cnt;
   logic [DIV_W-1:0] div_next;
   logic [2:0]       bit_cnt;
   logic [7:0]       shift;
   logic             bit_end;
   logic             push;
   logic             pop;

   assign o_full   = (count == DEPTH_CNT);
   assign o_empty  = (count == '0);
   assign o_count  = count;
   assign bit_end  = (baud_cnt == div - DIV_W'(1));
   assign div_next = (i_baud_div == '0) ? DIV_W'(1) : i_baud_div;
   assign push     = i_wr_en && !o_full;
   // Pop on leaving IDLE, or on the last stop-bit cycle so the next frame follows with no gap.
   assign pop      = !o_empty && ((state == IDLE) || ((state == STOP) && bit_end));

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         o_overflow <= 1'b0;
      end else begin
         o_overflow <= i_wr_en && o_full;
         if (push) begin
            mem[wr_ptr] <= i_wr_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            count <= count + (AW+1)'(1);
         else if (pop && !push)
            count <= count - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         div       <= DIV_W'(1);
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shift     <= '0;
         o_busy    <= 1'b0;
         o_uart_tx <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               o_uart_tx <= 1'b1;
               o_busy    <= 1'b0;
               if (pop) begin
                  shift     <= mem[rd_ptr];
                  div       <= div_next;
                  baud_cnt  <= '0;
                  bit_cnt   <= '0;
                  state     <= START;
                  o_uart_tx <= 1'b0;
                  o_busy    <= 1'b1;
               end
            end
            START: begin
               if (bit_end) begin
                  baud_cnt  <= '0;
                  bit_cnt   <= '0;
                  o_uart_tx <= shift[0];
                  shift     <= shift >> 1;
                  state     <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + DIV_W'(1);
               end
            end
            DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bit_cnt == 3'd7) begin
                     o_uart_tx <= 1'b1;
                     state     <= STOP;
                  end else begin
                     bit_cnt   <= bit_cnt + 3'd1;
                     o_uart_tx <= shift[0];
                     shift     <= shift >> 1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + DIV_W'(1);
               end
            end
            STOP: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (pop) begin
                     shift     <= mem[rd_ptr];
                     div       <= div_next;
                     bit_cnt   <= '0;
                     o_uart_tx <= 1'b0;
                     state     <= START;
                  end else begin
                     o_busy    <= 1'b0;
                     state     <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + DIV_W'(1);
               end
            end
            default: begin
               state     <= IDLE;
               o_uart_tx <= 1'b1;
               o_busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed writes push expected frames into a queue,
// and a line monitor pops and compares each frame as it appears on o_uart_tx.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

   localparam int DEPTH = 8;
   localparam int DIV_W = 16;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             i_wr_en;
   logic [7:0]       i_wr_data;
   logic [DIV_W-1:0] i_baud_div;
   logic             o_full;
   logic             o_empty;
   logic [CW-1:0]    o_count;
   logic             o_overflow;
   logic             o_busy;
   logic             o_uart_tx;

   uart_tx_fifo #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .i_wr_en    (i_wr_en),
      .i_wr_data  (i_wr_data),
      .i_baud_div (i_baud_div),
      .o_full     (o_full),
      .o_empty    (o_empty),
      .o_count    (o_count),
      .o_overflow (o_overflow),
      .o_busy     (o_busy),
      .o_uart_tx  (o_uart_tx)
   );

   // clock / cycle counter
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard state: each entry is {divisor, frame bits with bit 0 sent first}
   logic [DIV_W+9:0] exp_q[$];
   int n_checks    = 0;
   int n_fail      = 0;
   int frames_done = 0;
   int last_start  = -1;
   int prev_start  = -1;
   bit mon_active  = 1'b0;
   int wr_cyc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // driver: present one write for one edge; queue its frame if it should be sent
   task automatic push(input logic [7:0] d, input logic [9:0] frame, input int div, input bit accepted);
      i_wr_en   = 1'b1;
      i_wr_data = d;
      if (accepted)
         exp_q.push_back({DIV_W'(div), frame});
      @(posedge clk);
      #1;
      i_wr_en = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0 && !mon_active && o_busy === 1'b0)
            return;
         @(posedge clk);
         #1;
      end
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: timeout after %0d cycles, %0d frames still expected", budget, exp_q.size());
   endtask

   // monitor: a low line outside reset starts a frame; compare every cycle of it
   logic [DIV_W+9:0] m_item;
   logic [9:0]       m_frame;
   int               m_div;
   int               m_bad;
   bit               m_abort;
   logic             m_tx;
   logic             m_busy;

   initial begin
      forever begin
         @(negedge clk);
         if (reset !== 1'b0 || o_uart_tx !== 1'b0)
            continue;
         prev_start = last_start;
         last_start = cyc;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame: start bit at cycle %0d, expected none", cyc);
            while (o_uart_tx !== 1'b1) @(negedge clk);
            continue;
         end
         m_item     = exp_q.pop_front();
         m_frame    = m_item[9:0];
         m_div      = int'(m_item[DIV_W+9:10]);
         mon_active = 1'b1;
         m_bad      = -1;
         m_abort    = 1'b0;
         for (int k = 0; k < 10 * m_div; k++) begin
            if (k > 0) @(negedge clk);
            if (reset === 1'b1) begin
               m_abort = 1'b1;
               break;
            end
            if (m_bad < 0 && (o_uart_tx !== m_frame[k / m_div] || o_busy !== 1'b1)) begin
               m_bad  = k;
               m_tx   = o_uart_tx;
               m_busy = o_busy;
            end
         end
         mon_active = 1'b0;
         if (!m_abort) begin
            n_checks++;
            frames_done++;
            if (m_bad >= 0) begin
               n_fail++;
               $display("FAIL frame_%0d: cycle %0d of frame tx=%b busy=%b, expected tx=%b busy=1",
                        frames_done, m_bad, m_tx, m_busy, m_frame[m_bad / m_div]);
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b1;
      i_wr_en    = 1'b0;
      i_wr_data  = '0;
      i_baud_div = DIV_W'(4);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      check("reset_tx",       o_uart_tx,  1);
      check("reset_empty",    o_empty,    1);
      check("reset_full",     o_full,     0);
      check("reset_count",    o_count,    0);
      check("reset_busy",     o_busy,     0);
      check("reset_overflow", o_overflow, 0);

      // single byte 0xA5 at DIV=4: line 0,1,0,1,0,0,1,0,1,1
      i_baud_div = DIV_W'(4);
      push(8'hA5, 10'b11_0100_1010, 4, 1'b1);
      wr_cyc = cyc;
      repeat (40) @(posedge clk);
      #1;
      check("single_busy_last_cycle", o_busy, 1);
      @(posedge clk);
      #1;
      check("single_busy_after", o_busy, 0);
      check("single_idle_tx",    o_uart_tx, 1);
      check("single_latency",    last_start - wr_cyc, 1);
      check("single_frames",     frames_done, 1);

      // back-to-back 0x00, 0xFF at DIV=2
      i_baud_div = DIV_W'(2);
      push(8'h00, 10'b10_0000_0000, 2, 1'b1);
      check("b2b_count_1", o_count, 1);
      push(8'hFF, 10'b11_1111_1110, 2, 1'b1);
      check("b2b_count_2", o_count, 1);
      repeat (20) @(posedge clk);
      #1;
      check("b2b_count_3", o_count, 0);
      check("b2b_busy_between", o_busy, 1);
      wait_idle(200);
      check("b2b_gap", last_start - prev_start, 20);
      check("b2b_frames", frames_done, 3);

      // overflow: 10 writes into DEPTH=8 at DIV=100
      i_baud_div = DIV_W'(100);
      for (int i = 0; i < 10; i++) begin
         push(8'h30 + 8'(i), {1'b1, 8'h30 + 8'(i), 1'b0}, 100, i < 9);
         if (i == 8) begin
            check("ovf_full",       o_full,     1);
            check("ovf_count",      o_count,    8);
            check("ovf_no_pulse",   o_overflow, 0);
         end
         if (i == 9)
            check("ovf_pulse", o_overflow, 1);
      end
      @(posedge clk);
      #1;
      check("ovf_pulse_end", o_overflow, 0);
      wait_idle(10000);
      check("ovf_frames", frames_done, 12);

      // divisor 0 acts as 1; 0x3C gives 0,0,0,1,1,1,1,0,0,1
      i_baud_div = '0;
      push(8'h3C, 10'b10_0111_1000, 1, 1'b1);
      @(posedge clk);
      #1;
      i_baud_div = DIV_W'(8);
      repeat (9) @(posedge clk);
      #1;
      check("div0_busy_last_cycle", o_busy, 1);
      @(posedge clk);
      #1;
      check("div0_busy_after", o_busy, 0);
      wait_idle(100);
      check("div0_frames", frames_done, 13);

      // reset during the data bits of 0x55 with 0x66 still queued
      i_baud_div = DIV_W'(4);
      push(8'h55, 10'b10_1010_1010, 4, 1'b1);
      push(8'h66, 10'b10_1100_1100, 4, 1'b0);
      repeat (8) @(posedge clk);
      #1;
      check("midrst_busy_before", o_busy, 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_tx",    o_uart_tx, 1);
      check("midrst_count", o_count,   0);
      check("midrst_busy",  o_busy,    0);
      check("midrst_empty", o_empty,   1);
      reset = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      check("midrst_idle_tx", o_uart_tx, 1);
      check("midrst_frames",  frames_done, 13);
      check("final_queue",    exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
